// File: rtl/tdc_pkg.sv
// Shared constants and FSM encoding for the TDC phase-difference back-end.
// Widths: counter, thermometer, fraction, raw sample and output word.
package tdc_pkg;

    localparam int CNT_W    = 7;
    localparam int PH_W     = 16;
    localparam int FRAC_W   = 4;
    localparam int RAW_W    = CNT_W + FRAC_W;
    localparam int WORD_W   = RAW_W + 1;
    localparam int MAX_JUMP = 8;
    localparam int HOLD_MAX = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

endpackage

// File: rtl/tdc_phase_diff_if.sv
// Bus bundle between the ADPLL controller side and the TDC back-end.
// master drives en/tdc_pd/counter_in/phase_in/clr_stats; slave returns the word and stats.
interface tdc_phase_diff_if;
    import tdc_pkg::*;

    logic              en;
    logic              tdc_pd;
    logic [CNT_W-1:0]  counter_in;
    logic [PH_W-1:0]   phase_in;
    logic              clr_stats;
    logic [WORD_W-1:0] tdc_word;
    logic              word_valid;
    logic              glitch;
    logic [7:0]        glitch_cnt;

    modport master (
        output en, tdc_pd, counter_in, phase_in, clr_stats,
        input  tdc_word, word_valid, glitch, glitch_cnt
    );

    modport slave (
        input  en, tdc_pd, counter_in, phase_in, clr_stats,
        output tdc_word, word_valid, glitch, glitch_cnt
    );

endinterface

// File: rtl/therm_bubble_dec.sv
// Thermometer bubble corrector and ones-run counter (combinational).
// therm: PH_W taps, bit0 earliest; frac: leading-ones run from bit0, saturating at 2^FRAC_W-1.
module therm_bubble_dec
    import tdc_pkg::*;
(
    input  logic [PH_W-1:0]   therm,
    output logic [FRAC_W-1:0] frac
);

    // Pad with a 1 below bit0 and a 0 above the top tap.
    logic [PH_W+1:0] ext;
    logic [PH_W-1:0] fixd;
    logic            run;

    assign ext = {1'b0, therm, 1'b1};

    always_comb begin
        fixd = '0;
        for (int i = 0; i < PH_W; i++) begin
            fixd[i] = (ext[i] & ext[i+1]) |
                      (ext[i] & ext[i+2]) |
                      (ext[i+1] & ext[i+2]);
        end
    end

    // First zero at position i means a run of i ones; a full run saturates.
    always_comb begin
        frac = FRAC_W'(PH_W - 1);
        run  = 1'b1;
        for (int i = 0; i < PH_W - 1; i++) begin
            if (run && !fixd[i]) begin
                frac = FRAC_W'(i);
                run  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tdc_phase_diff.sv
// TDC back-end: per-reference-period DCO phase increment with outlier rejection.
// Ports: clk, rst (sync active-low), bus (slave): en, tdc_pd, counter_in, phase_in, clr_stats -> tdc_word, word_valid, glitch, glitch_cnt.
module tdc_phase_diff
    import tdc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    tdc_phase_diff_if.slave bus
);

    logic              act;
    logic [CNT_W-1:0]  cnt_s;
    logic [PH_W-1:0]   ph_s;
    logic [FRAC_W-1:0] frac_s;
    logic [RAW_W-1:0]  raw;
    logic [RAW_W-1:0]  raw_prev;
    logic [1:0]        state;
    logic [1:0]        fill;
    logic [1:0]        rej_cnt;
    logic [WORD_W-1:0] tdc_word;
    logic              word_valid;
    logic              glitch;
    logic [7:0]        glitch_cnt;
    logic [WORD_W-1:0] cand;
    logic [8:0]        d_s;
    logic [8:0]        d_abs;
    logic              jump;
    logic              hold_ok;

    assign act = bus.en & ~bus.tdc_pd;

    therm_bubble_dec u_dec (
        .therm (ph_s),
        .frac  (frac_s)
    );

    // Modulo-2^11 difference absorbs the ripple-counter wrap.
    assign cand    = {1'b0, raw - raw_prev};
    assign d_s     = {1'b0, cand[WORD_W-1:FRAC_W]}
                   - {1'b0, tdc_word[WORD_W-1:FRAC_W]};
    assign d_abs   = d_s[8] ? (~d_s + 9'd1) : d_s;
    assign jump    = d_abs > 9'(MAX_JUMP);
    assign hold_ok = rej_cnt < 2'(HOLD_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_s      <= '0;
            ph_s       <= '0;
            raw        <= '0;
            raw_prev   <= '0;
            state      <= IDLE;
            fill       <= '0;
            rej_cnt    <= '0;
            tdc_word   <= '0;
            word_valid <= 1'b0;
            glitch     <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            glitch <= 1'b0;
            if (!act) begin
                state      <= IDLE;
                word_valid <= 1'b0;
            end else begin
                cnt_s    <= bus.counter_in;
                ph_s     <= bus.phase_in;
                raw      <= {cnt_s, frac_s};
                raw_prev <= raw;
                unique case (state)
                    IDLE: begin
                        state <= FILL;
                        fill  <= '0;
                    end
                    FILL: begin
                        if (fill == 2'd2) begin
                            // First real difference: never filtered.
                            state      <= RUN;
                            word_valid <= 1'b1;
                            tdc_word   <= cand;
                            rej_cnt    <= '0;
                        end else begin
                            fill <= fill + 2'd1;
                        end
                    end
                    RUN: begin
                        if (jump && hold_ok) begin
                            glitch  <= 1'b1;
                            rej_cnt <= rej_cnt + 2'd1;
                            if (glitch_cnt != 8'hFF) begin
                                glitch_cnt <= glitch_cnt + 8'd1;
                            end
                        end else begin
                            tdc_word <= cand;
                            rej_cnt  <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // A clear wins over a same-cycle increment.
            if (bus.clr_stats) begin
                glitch_cnt <= '0;
            end
        end
    end

    assign bus.tdc_word   = tdc_word;
    assign bus.word_valid = word_valid;
    assign bus.glitch     = glitch;
    assign bus.glitch_cnt = glitch_cnt;

endmodule

// File: tb/tb_tdc_phase_diff.sv
// Bench for tdc_phase_diff: directed scenarios plus random stream vs. a sample-history model.
// Drives the bus interface; compares all outputs every cycle.
module tb_tdc_phase_diff;
    import tdc_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tdc_phase_diff_if bus();

    tdc_phase_diff dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] therm(input int n);
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < n; i++) t[i] = 1'b1;
        return t;
    endfunction

    // Majority-voted leading-ones count, saturating at 15.
    function automatic int model_frac(input logic [15:0] ph);
        logic [17:0] e;
        int n;
        e = {1'b0, ph, 1'b1};
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (int'(e[i]) + int'(e[i+1]) + int'(e[i+2]) < 2) break;
            n++;
        end
        return (n > 15) ? 15 : n;
    endfunction

    function automatic logic [10:0] sample_raw(input logic [6:0] c,
                                               input logic [15:0] ph);
        return {c, 4'(model_frac(ph))};
    endfunction

    // Model: keeps the last three samples of the current unbroken active run.
    logic [10:0] q[$];
    int          k;
    bit          model_on;
    logic [11:0] m_word;
    logic [11:0] m_cand;
    bit          m_wv;
    bit          m_g;
    int          m_gcnt;
    int          m_rej;
    int          m_jump;

    initial begin
        model_on = 0;
        k = 0;
        m_word = '0;
        m_cand = '0;
        m_wv = 0;
        m_g = 0;
        m_gcnt = 0;
        m_rej = 0;
        m_jump = 0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            k = 0;
            q.delete();
            m_word = '0;
            m_wv = 0;
            m_g = 0;
            m_gcnt = 0;
            m_rej = 0;
            model_on = 1;
        end else begin
            m_g = 0;
            if (!(bus.en && !bus.tdc_pd)) begin
                k = 0;
                m_wv = 0;
                q.delete();
            end else begin
                if (k < 100) k++;
                if (k >= 4) begin
                    m_cand = {1'b0, q[1] - q[0]};
                    m_jump = int'(m_cand[11:4]) - int'(m_word[11:4]);
                    if (m_jump < 0) m_jump = -m_jump;
                    if (k > 4 && m_jump > 8 && m_rej < 2) begin
                        m_g = 1;
                        m_rej++;
                        if (m_gcnt < 255) m_gcnt++;
                    end else begin
                        m_word = m_cand;
                        m_rej = 0;
                    end
                end
                m_wv = (k >= 4);
                q.push_back(sample_raw(bus.counter_in, bus.phase_in));
                if (q.size() > 3) void'(q.pop_front());
            end
            if (bus.clr_stats) m_gcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("word", int'(bus.tdc_word), int'(m_word));
            chk("valid", int'(bus.word_valid), int'(m_wv));
            chk("glitch", int'(bus.glitch), int'(m_g));
            chk("gcnt", int'(bus.glitch_cnt), m_gcnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_raw(input logic [10:0] r);
        bus.counter_in = r[10:4];
        bus.phase_in   = therm(int'(r[3:0]));
    endtask

    logic [10:0] r;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.en = 1'b0;
        bus.tdc_pd = 1'b0;
        bus.clr_stats = 1'b0;
        bus.counter_in = '0;
        bus.phase_in = '0;

        chk("pin_frac_7b", model_frac(16'h007B), 7);
        chk("pin_frac_ffff", model_frac(16'hFFFF), 15);
        chk("pin_frac_0001", model_frac(16'h0001), 1);
        chk("pin_frac_0000", model_frac(16'h0000), 0);

        repeat (3) tick();
        chk("rst_word", int'(bus.tdc_word), 0);
        chk("rst_valid", int'(bus.word_valid), 0);
        chk("rst_glitch", int'(bus.glitch), 0);
        chk("rst_gcnt", int'(bus.glitch_cnt), 0);
        rst = 1'b1;

        // Basic: 10/5 ones then 85/9 ones.
        bus.en = 1'b1;
        drive_raw(11'd165); tick();
        r = 11'd1369; drive_raw(r); tick();
        r += 11'd1204; drive_raw(r); tick();
        chk("t1_valid_e3", int'(bus.word_valid), 0);
        r += 11'd1204; drive_raw(r); tick();
        chk("t1_valid_e4", int'(bus.word_valid), 1);
        chk("t1_word", int'(bus.tdc_word), 'h4B4);
        repeat (4) begin r += 11'd1204; drive_raw(r); tick(); end

        // Single outlier held.
        r += 11'h5B4; drive_raw(r); tick();
        r += 11'd1204; drive_raw(r); tick();
        r += 11'd1204; drive_raw(r); tick();
        chk("t4_hold", int'(bus.tdc_word), 'h4B4);
        chk("t4_glitch", int'(bus.glitch), 1);
        chk("t4_gcnt", int'(bus.glitch_cnt), 1);

        // Three consecutive outliers: third one accepted.
        repeat (3) begin r += 11'h5B4; drive_raw(r); tick(); end
        r += 11'd1204; drive_raw(r); tick();
        r += 11'd1204; drive_raw(r); tick();
        chk("t4_third", int'(bus.tdc_word), 'h5B4);
        chk("t4_gcnt3", int'(bus.glitch_cnt), 3);
        repeat (6) begin r += 11'd1204; drive_raw(r); tick(); end

        // Gating via en and tdc_pd.
        bus.en = 1'b0;
        r += 11'd1204; drive_raw(r); tick();
        chk("t5_en_valid", int'(bus.word_valid), 0);
        chk("t5_en_word", int'(bus.tdc_word), 'h4B4);
        bus.en = 1'b1;
        bus.tdc_pd = 1'b1;
        r += 11'd1204; drive_raw(r); tick();
        chk("t5_pd_valid", int'(bus.word_valid), 0);
        bus.tdc_pd = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            r += 11'd1204; drive_raw(r); tick();
            chk("t5_refill", int'(bus.word_valid), (i == 4) ? 1 : 0);
        end

        // Counter wrap.
        bus.en = 1'b0; tick();
        bus.en = 1'b1;
        drive_raw(11'd1923); tick();
        r = 11'd1073; drive_raw(r); tick();
        repeat (2) begin r += 11'd1198; drive_raw(r); tick(); end
        chk("t2_wrap", int'(bus.tdc_word), 'h4AE);

        // Bubble decode through the datapath.
        bus.en = 1'b0; tick();
        bus.en = 1'b1;
        bus.counter_in = 7'd0; bus.phase_in = 16'h0000; tick();
        bus.counter_in = 7'd5; bus.phase_in = 16'h007B; tick();
        repeat (2) tick();
        chk("t3_7b", int'(bus.tdc_word), 'h057);
        bus.en = 1'b0; tick();
        bus.en = 1'b1;
        bus.counter_in = 7'd0; bus.phase_in = 16'h0000; tick();
        bus.counter_in = 7'd5; bus.phase_in = 16'hFFFF; tick();
        repeat (2) tick();
        chk("t3_ffff", int'(bus.tdc_word), 'h05F);

        // Reset mid-run.
        r = 11'd100;
        repeat (6) begin r += 11'd1204; drive_raw(r); tick(); end
        rst = 1'b0; tick();
        chk("t6_rst_word", int'(bus.tdc_word), 0);
        chk("t6_rst_valid", int'(bus.word_valid), 0);
        chk("t6_rst_gcnt", int'(bus.glitch_cnt), 0);
        rst = 1'b1;

        // Clear together with an outlier.
        repeat (5) begin r += 11'd1204; drive_raw(r); tick(); end
        r += 11'h5B4; drive_raw(r); tick();
        r += 11'd1204; drive_raw(r); tick();
        r += 11'd1204; drive_raw(r); bus.clr_stats = 1'b1; tick();
        bus.clr_stats = 1'b0;
        chk("t6_clr_glitch", int'(bus.glitch), 1);
        chk("t6_clr_gcnt", int'(bus.glitch_cnt), 0);

        // Random stream.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 500) != 0;
            bus.en = ($urandom % 40) != 0;
            bus.tdc_pd = ($urandom % 80) == 0;
            bus.clr_stats = ($urandom % 100) == 0;
            case ($urandom % 20)
                0: r += 11'($urandom);
                1: r += 11'h5B4;
                2: r += 11'h3B4;
                default: r += 11'(1204 + $urandom_range(0, 6) - 3);
            endcase
            drive_raw(r);
            if (($urandom % 10) == 0)
                bus.phase_in = bus.phase_in ^ 16'(1 << ($urandom % 16));
            else if (($urandom % 30) == 0)
                bus.phase_in = 16'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
